// File: rtl/anchor_clkmon.sv
// anchor_clkmon: frequency monitor for the anchor data clock.
// Counts both edges of a divided toggle from the d_clk domain over a fixed
// m_clk gate window, range-checks the count and debounces it into clk_ok
// plus a sticky fault flag.
module anchor_clkmon #(
    parameter int GATE_CYCLES = 100000,
    parameter int CNT_W       = 20,
    parameter int CNT_MIN     = 15200,
    parameter int CNT_MAX     = 15520,
    parameter int OK_LIMIT    = 4,
    parameter int FAIL_LIMIT  = 2
) (
    input  logic             m_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tgl_in,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             in_range,
    output logic             clk_ok,
    output logic             fault_sticky
);

    localparam int PH_W   = $clog2(GATE_CYCLES + 1);
    localparam int OK_W   = $clog2(OK_LIMIT + 1);
    localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);

    localparam logic [PH_W-1:0]   ARM_LAST  = PH_W'(2);
    localparam logic [PH_W-1:0]   MEAS_LAST = PH_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(CNT_MAX);
    localparam logic [OK_W-1:0]   OK_MAX    = OK_W'(OK_LIMIT);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(FAIL_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PH_W-1:0]     phase_r;
    logic                sync1_r;
    logic                sync2_r;
    logic                dly_r;
    logic                edge_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [OK_W-1:0]     ok_run_r;
    logic [OK_W-1:0]     ok_nxt_s;
    logic [FAIL_W-1:0]   fail_run_r;
    logic [FAIL_W-1:0]   fail_nxt_s;
    logic                win_ok_s;
    logic                report_s;
    logic                fall_s;

    // Inclusive acceptance window check on a completed count.
    function automatic logic range_ok(input logic [CNT_W-1:0] c);
        return (c >= CNT_LO) && (c <= CNT_HI);
    endfunction

    // Two-stage synchronizer for the asynchronous toggle plus the edge-compare register.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dly_r   <= 1'b0;
        end else begin
            sync1_r <= tgl_in;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    // Any difference between synchronized and delayed level is one transition.
    assign edge_s = sync2_r ^ dly_r;

    // FSM state register.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: dropping en always returns to IDLE on the next edge.
    always_comb begin
        state_nxt_s = state_r;
        if (!en) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_nxt_s = ST_ARM;
                ST_ARM:     state_nxt_s = (phase_r == ARM_LAST) ? ST_MEASURE : ST_ARM;
                ST_MEASURE: state_nxt_s = (phase_r == MEAS_LAST) ? ST_REPORT : ST_MEASURE;
                ST_REPORT:  state_nxt_s = ST_MEASURE;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Phase counter times ARM and MEASURE; restarts on every state change.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            phase_r <= {PH_W{1'b0}};
        end else if ((state_r == ST_IDLE) || (state_nxt_s != state_r)) begin
            phase_r <= {PH_W{1'b0}};
        end else begin
            phase_r <= phase_r + PH_W'(1);
        end
    end

    // Transition counter: counts only in MEASURE, saturates, and is cleared elsewhere
    // so an edge seen during REPORT is dropped.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_MEASURE) begin
            if (edge_s && (cnt_r != CNT_SAT)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Debounce run counters as they would be after this window's verdict.
    always_comb begin
        win_ok_s   = range_ok(cnt_r);
        ok_nxt_s   = ok_run_r;
        fail_nxt_s = fail_run_r;
        if (win_ok_s) begin
            fail_nxt_s = {FAIL_W{1'b0}};
            ok_nxt_s   = (ok_run_r == OK_MAX) ? ok_run_r : ok_run_r + OK_W'(1);
        end else begin
            ok_nxt_s   = {OK_W{1'b0}};
            fail_nxt_s = (fail_run_r == FAIL_MAX) ? fail_run_r : fail_run_r + FAIL_W'(1);
        end
    end

    assign report_s = en && (state_r == ST_REPORT);
    assign fall_s   = report_s && clk_ok && !win_ok_s && (fail_nxt_s == FAIL_MAX);

    // Window result, valid pulse and debounced status; IDLE forgets clk_ok history.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            meas_cnt   <= {CNT_W{1'b0}};
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            clk_ok     <= 1'b0;
            ok_run_r   <= {OK_W{1'b0}};
            fail_run_r <= {FAIL_W{1'b0}};
        end else if (!en || (state_r == ST_IDLE)) begin
            meas_valid <= 1'b0;
            clk_ok     <= 1'b0;
            ok_run_r   <= {OK_W{1'b0}};
            fail_run_r <= {FAIL_W{1'b0}};
        end else if (report_s) begin
            meas_cnt   <= cnt_r;
            in_range   <= win_ok_s;
            meas_valid <= 1'b1;
            ok_run_r   <= ok_nxt_s;
            fail_run_r <= fail_nxt_s;
            if (ok_nxt_s == OK_MAX) begin
                clk_ok <= 1'b1;
            end else if (fail_nxt_s == FAIL_MAX) begin
                clk_ok <= 1'b0;
            end else begin
                clk_ok <= clk_ok;
            end
        end else begin
            meas_valid <= 1'b0;
        end
    end

    // Sticky fault: set by a debounced clk_ok fall, which wins over a same-cycle clear.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            fault_sticky <= 1'b0;
        end else if (fall_s) begin
            fault_sticky <= 1'b1;
        end else if (clr_fault) begin
            fault_sticky <= 1'b0;
        end else begin
            fault_sticky <= fault_sticky;
        end
    end

endmodule
